// File: rtl/dec_scan_n.sv
// dec_scan_n - registered one-hot decoder with a built-in scan sequencer.
//
// Drives LED banks / 7-segment digit enables. In direct mode the binary
// select is decoded into a registered one-hot word. In the scan modes the
// active bit walks up, down or back and forth, advancing once every
// dwell+1 clock cycles, so no external counter is needed.
//
// Parameters:
//   SEL_W      index width; output width is 1 << SEL_W
//   DWELL_W    width of the dwell value and the internal prescaler
//   ACTIVE_LOW 1 = out is inverted (active bit 0, all others 1)
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset
//   en     in   1 = run; 0 = hold state, blank out, no pulses
//   mode   in   00 direct, 01 scan up, 10 scan down, 11 bounce
//   sel    in   direct-mode index; start index for load
//   load   in   scan modes: force index to sel (wins over an advance)
//   dwell  in   step period minus one, in clock cycles
//   out    out  registered one-hot of idx (polarity per ACTIVE_LOW)
//   idx    out  registered current index
//   step   out  one-cycle pulse on each scan advance
//   wrap   out  one-cycle pulse on wrap (up/down) or turnaround (bounce)
module dec_scan_n #(
  parameter int SEL_W      = 3,
  parameter int DWELL_W    = 24,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     load,
  input  logic [DWELL_W-1:0]       dwell,
  output logic [(1 << SEL_W)-1:0]  out,
  output logic [SEL_W-1:0]         idx,
  output logic                     step,
  output logic                     wrap
);

  localparam int OUT_W = 1 << SEL_W;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_UP     = 2'b01;
  localparam logic [1:0] MODE_DOWN   = 2'b10;
  localparam logic [1:0] MODE_BOUNCE = 2'b11;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam logic [SEL_W-1:0]   IDX_MAX  = '1;
  localparam logic [SEL_W-1:0]   IDX_ZERO = '0;
  localparam logic [SEL_W-1:0]   IDX_ONE  = {{(SEL_W-1){1'b0}}, 1'b1};
  localparam logic [DWELL_W-1:0] CNT_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};
  localparam logic [OUT_W-1:0]   ONEHOT0  = {{(OUT_W-1){1'b0}}, 1'b1};
  localparam logic [OUT_W-1:0]   INACTIVE = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [DWELL_W-1:0] cnt, cnt_n;
  logic               dir, dir_n;
  logic [1:0]         mode_q;
  // mode_q holds no meaningful history straight after reset; without this
  // flag the first enabled cycle would look like a mode change and delay
  // the first advance by one cycle.
  logic               mode_vld;
  logic               mode_chg;

  logic [SEL_W-1:0]   idx_n;
  logic               step_n, wrap_n;
  logic [OUT_W-1:0]   out_n;

  logic [SEL_W-1:0]   adv_idx;
  logic               adv_wrap;
  logic               adv_dir;
  logic               eff_up;

  assign mode_chg = mode_vld && (mode != mode_q);

  // Bounce direction: endpoints force the only legal direction, so a load
  // or mode change that left dir=up at the top still turns around cleanly.
  always_comb begin
    eff_up = dir;
    if (idx == IDX_ZERO)     eff_up = DIR_UP;
    else if (idx == IDX_MAX) eff_up = DIR_DOWN;
  end

  // Next index / pulse / direction if an advance happens this cycle.
  always_comb begin
    adv_idx  = idx;
    adv_wrap = 1'b0;
    adv_dir  = dir;
    case (mode)
      MODE_UP: begin
        adv_idx  = idx + IDX_ONE;
        adv_wrap = (idx == IDX_MAX);
      end
      MODE_DOWN: begin
        adv_idx  = idx - IDX_ONE;
        adv_wrap = (idx == IDX_ZERO);
      end
      MODE_BOUNCE: begin
        adv_idx  = eff_up ? (idx + IDX_ONE) : (idx - IDX_ONE);
        adv_wrap = (adv_idx == IDX_MAX) || (adv_idx == IDX_ZERO);
        if (adv_idx == IDX_MAX)       adv_dir = DIR_DOWN;
        else if (adv_idx == IDX_ZERO) adv_dir = DIR_UP;
        else                          adv_dir = eff_up;
      end
      default: ;
    endcase
  end

  always_comb begin
    idx_n  = idx;
    cnt_n  = cnt;
    dir_n  = dir;
    step_n = 1'b0;
    wrap_n = 1'b0;
    if (en) begin
      if (mode == MODE_DIRECT) begin
        idx_n = sel;
        cnt_n = '0;
        dir_n = DIR_UP;
      end else if (load) begin
        idx_n = sel;
        cnt_n = '0;
        dir_n = (mode == MODE_BOUNCE && sel == IDX_MAX) ? DIR_DOWN : DIR_UP;
      end else if (mode_chg) begin
        cnt_n = '0;
        dir_n = DIR_UP;
      end else if (cnt >= dwell) begin
        // >= so that shrinking dwell mid-count advances at once.
        cnt_n  = '0;
        idx_n  = adv_idx;
        dir_n  = adv_dir;
        step_n = 1'b1;
        wrap_n = adv_wrap;
      end else begin
        cnt_n = cnt + CNT_ONE;
      end
    end
  end

  // out is decoded from the next index so idx and out change together.
  assign out_n = en ? ((ONEHOT0 << idx_n) ^ INACTIVE) : INACTIVE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      cnt      <= '0;
      dir      <= DIR_UP;
      mode_q   <= MODE_DIRECT;
      mode_vld <= 1'b0;
      step     <= 1'b0;
      wrap     <= 1'b0;
      out      <= INACTIVE;
    end else begin
      idx  <= idx_n;
      cnt  <= cnt_n;
      dir  <= dir_n;
      step <= step_n;
      wrap <= wrap_n;
      out  <= out_n;
      if (en) begin
        mode_q   <= mode;
        mode_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dec_scan_n.sv
// tb_dec_scan_n - directed self-checking bench for dec_scan_n.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_dec_scan_n;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [2:0] sel;
  logic       load;
  logic [23:0] dwell;
  logic [7:0] out;
  logic [7:0] out_al;
  logic [2:0] idx;
  logic [2:0] idx_al;
  logic       step, step_al;
  logic       wrap, wrap_al;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  dec_scan_n #(.SEL_W(3), .DWELL_W(24), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .load(load),
    .dwell(dwell), .out(out), .idx(idx), .step(step), .wrap(wrap)
  );

  dec_scan_n #(.SEL_W(3), .DWELL_W(24), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .load(load),
    .dwell(dwell), .out(out_al), .idx(idx_al), .step(step_al), .wrap(wrap_al)
  );

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // d quiet cycles holding idx at prev, then one advance to nxt.
  task automatic wait_adv(input logic [2:0] prev, input logic [2:0] nxt,
                          input logic w, input int d);
    logic [7:0] e;
    for (int i = 0; i < d; i++) begin
      tick();
      e = 8'h01 << prev;
      chk("hold_idx", 32'(idx), 32'(prev));
      chk("hold_out", 32'(out), 32'(e));
      chk("hold_step", 32'(step), 32'd0);
    end
    tick();
    e = 8'h01 << nxt;
    chk("adv_idx", 32'(idx), 32'(nxt));
    chk("adv_out", 32'(out), 32'(e));
    chk("adv_step", 32'(step), 32'd1);
    chk("adv_wrap", 32'(wrap), 32'(w));
  endtask

  logic [2:0] bseq [15] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
                            3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};

  initial begin
    logic [2:0] prev;
    logic [7:0] e;
    rst = 1'b1; en = 1'b0; mode = 2'b00; sel = 3'd0; load = 1'b0; dwell = 24'd0;

    // Reset values while rst is high.
    #12;
    chk("rst_out", 32'(out), 32'h00);
    chk("rst_idx", 32'(idx), 32'd0);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    chk("rst_out_al", 32'(out_al), 32'hFF);

    // Direct mode.
    tick();
    rst = 1'b0; en = 1'b1; sel = 3'd5;
    tick();
    chk("dir5_out", 32'(out), 32'h20);
    chk("dir5_idx", 32'(idx), 32'd5);
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      tick();
      e = 8'h01 << s;
      chk("sweep_out", 32'(out), 32'(e));
      chk("sweep_step", 32'(step), 32'd0);
    end

    // Scan up, dwell=2, start at 6.
    mode = 2'b01; dwell = 24'd2; sel = 3'd6; load = 1'b1;
    tick();
    load = 1'b0;
    chk("load6_idx", 32'(idx), 32'd6);
    chk("load6_step", 32'(step), 32'd0);
    wait_adv(3'd6, 3'd7, 1'b0, 2);
    wait_adv(3'd7, 3'd0, 1'b1, 2);
    wait_adv(3'd0, 3'd1, 1'b0, 2);

    // Enable/blank: one count consumed, then 5 blanked cycles.
    tick();
    chk("pre_blank_idx", 32'(idx), 32'd1);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("blank_out", 32'(out), 32'h00);
      chk("blank_idx", 32'(idx), 32'd1);
      chk("blank_step", 32'(step), 32'd0);
      chk("blank_wrap", 32'(wrap), 32'd0);
    end
    en = 1'b1;
    tick();
    chk("reen_out", 32'(out), 32'h02);
    chk("reen_step", 32'(step), 32'd0);
    tick();
    chk("resume_idx", 32'(idx), 32'd2);
    chk("resume_step", 32'(step), 32'd1);

    // Load coincident with an advance.
    tick();
    tick();
    chk("preload_idx", 32'(idx), 32'd2);
    load = 1'b1; sel = 3'd4;
    tick();
    load = 1'b0;
    chk("ldpri_idx", 32'(idx), 32'd4);
    chk("ldpri_out", 32'(out), 32'h10);
    chk("ldpri_step", 32'(step), 32'd0);
    wait_adv(3'd4, 3'd5, 1'b0, 2);

    // Mode change up->down on the cycle an advance was due.
    tick();
    tick();
    mode = 2'b10;
    tick();
    chk("mchg_idx", 32'(idx), 32'd5);
    chk("mchg_step", 32'(step), 32'd0);
    wait_adv(3'd5, 3'd4, 1'b0, 2);
    wait_adv(3'd4, 3'd3, 1'b0, 2);

    // Bounce, dwell=0, from 0.
    mode = 2'b11; dwell = 24'd0; sel = 3'd0; load = 1'b1;
    tick();
    load = 1'b0;
    chk("b_load_idx", 32'(idx), 32'd0);
    chk("b_out_al0", 32'(out_al), 32'hFE);
    prev = 3'd0;
    for (int i = 0; i < 15; i++) begin
      wait_adv(prev, bseq[i], (bseq[i] == 3'd7) || (bseq[i] == 3'd0), 0);
      if (bseq[i] == 3'd0) chk("b_out_al_end", 32'(out_al), 32'hFE);
      prev = bseq[i];
    end

    // Asynchronous reset mid-scan.
    #3;
    rst = 1'b1;
    #1;
    chk("arst_out", 32'(out), 32'h00);
    chk("arst_idx", 32'(idx), 32'd0);
    chk("arst_step", 32'(step), 32'd0);
    chk("arst_wrap", 32'(wrap), 32'd0);
    chk("arst_out_al", 32'(out_al), 32'hFF);
    mode = 2'b01; dwell = 24'd2;
    tick();
    rst = 1'b0;
    wait_adv(3'd0, 3'd1, 1'b0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
